// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver:
// parity mode constants, receiver FSM state encoding and a frame-length helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Total bit cells in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// uart_bit_sampler: input conditioning for the UART receiver.
//   clk, rst    : clock, synchronous active-high reset
//   ena         : receiver enable (gates edge detection)
//   serial_in   : asynchronous line, idle high
//   cnt, half   : bit-cell counter and its mid-point from the receiver
//   line        : synchronised line level
//   sample_bit  : 3-sample majority, valid at cnt == half+1
//   fall_edge   : synchronised 1->0 transition while enabled
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             serial_in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] half,
  output logic             line,
  output logic             sample_bit,
  output logic             fall_edge
);

  logic sync1, sync2, prev;
  logic smp_a, smp_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (cnt == half - CNT_W'(1)) smp_a <= sync2;
      if (cnt == half)             smp_b <= sync2;
    end
  end

  assign line      = sync2;
  assign fall_edge = ena && prev && !sync2;
  // Third vote is the live sample, so the result is ready at cnt == half+1.
  assign sample_bit = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority sampling,
// start-glitch rejection, parity/framing/overrun reporting and a
// valid/ready output handshake.
//   clk, rst   : clock, synchronous active-high reset
//   ena        : receiver enable; low aborts any word in flight
//   serial_in  : asynchronous UART line, idle high
//   rx_data    : received word (LSB first on the line)
//   rx_valid   : rx_data / frame_err / parity_err valid
//   rx_ready   : consumer accepts when rx_valid && rx_ready
//   frame_err  : stop bit sampled 0
//   parity_err : parity mismatch
//   overrun    : sticky, a completed word was dropped
//   busy       : FSM not idle
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned      HALF       = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);
  localparam logic [3:0]       IDX_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       IDX_LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_t state, state_n;

  logic [CNT_W-1:0]     cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc, par_err_acc, frame_acc;
  logic                 line, sample_bit, fall_edge;
  logic                 decide, complete, handshake, word_fe;

  uart_bit_sampler #(
    .CNT_W (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .serial_in  (serial_in),
    .cnt        (cnt),
    .half       (CNT_HALF),
    .line       (line),
    .sample_bit (sample_bit),
    .fall_edge  (fall_edge)
  );

  assign decide    = (cnt == CNT_DECIDE);
  assign word_fe   = frame_acc | ~sample_bit;
  assign handshake = rx_valid && rx_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    complete = 1'b0;
    case (state)
      ST_IDLE:   if (fall_edge) state_n = ST_START;
      ST_START:  if (decide) state_n = sample_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && idx == IDX_LAST_DATA)
                   state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (decide) state_n = ST_STOP;
      ST_STOP:   if (decide && idx == IDX_LAST_STOP) begin
                   complete = ena;
                   state_n  = word_fe ? ST_BREAK : ST_IDLE;
                 end
      ST_BREAK:  if (line) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (!ena) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      par_acc     <= 1'b0;
      par_err_acc <= 1'b0;
      frame_acc   <= 1'b0;
    end else begin
      // The edge-detection cycle counts as cnt=0, so START begins at 1.
      if (state == ST_IDLE || state == ST_BREAK) cnt <= CNT_W'(1);
      else if (cnt == CNT_LAST)                  cnt <= '0;
      else                                       cnt <= cnt + 1'b1;

      if (decide) begin
        case (state)
          ST_START: begin
            idx         <= '0;
            par_acc     <= 1'b0;
            par_err_acc <= 1'b0;
            frame_acc   <= 1'b0;
          end
          ST_DATA: begin
            shift   <= {sample_bit, shift[DATA_BITS-1:1]};
            par_acc <= par_acc ^ sample_bit;
            idx     <= (idx == IDX_LAST_DATA) ? '0 : idx + 1'b1;
          end
          ST_PARITY:
            par_err_acc <= (PARITY == PARITY_ODD) ? ~(par_acc ^ sample_bit)
                                                  :  (par_acc ^ sample_bit);
          ST_STOP: begin
            idx <= idx + 1'b1;
            if (!sample_bit) frame_acc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A slot is free if empty or being emptied by a handshake this cycle.
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data    <= shift;
        frame_err  <= word_fe;
        parity_err <= (PARITY != PARITY_NONE) && par_err_acc;
        rx_valid   <= 1'b1;
      end else if (handshake) begin
        rx_valid <= 1'b0;
      end

      if (complete && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (handshake)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7N2) at 16 clocks/bit.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int unsigned CPB   = 16;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned NONE  = 99;
  localparam int unsigned NDATA [3] = '{8, 8, 7};
  localparam int unsigned NPAR  [3] = '{0, 2, 0};
  localparam int unsigned NSTOP [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ena, ser, rdy;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       vld0, vld1, vld2, fe0, fe1, fe2, pe0, pe1, pe2;
  logic       ovr0, ovr1, ovr2, bsy0, bsy1, bsy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(NDATA[0]), .PARITY(NPAR[0]), .STOP_BITS(NSTOP[0])) u0 (
    .clk(clk), .rst(rst), .ena(ena[0]), .serial_in(ser[0]), .rx_data(d0), .rx_valid(vld0),
    .rx_ready(rdy[0]), .frame_err(fe0), .parity_err(pe0), .overrun(ovr0), .busy(bsy0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(NDATA[1]), .PARITY(NPAR[1]), .STOP_BITS(NSTOP[1])) u1 (
    .clk(clk), .rst(rst), .ena(ena[1]), .serial_in(ser[1]), .rx_data(d1), .rx_valid(vld1),
    .rx_ready(rdy[1]), .frame_err(fe1), .parity_err(pe1), .overrun(ovr1), .busy(bsy1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(NDATA[2]), .PARITY(NPAR[2]), .STOP_BITS(NSTOP[2])) u2 (
    .clk(clk), .rst(rst), .ena(ena[2]), .serial_in(ser[2]), .rx_data(d2), .rx_valid(vld2),
    .rx_ready(rdy[2]), .frame_err(fe2), .parity_err(pe2), .overrun(ovr2), .busy(bsy2));

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb0[$], sb1[$], sb2[$];

  typedef struct {
    int unsigned dut;
    logic [8:0]  data;
    logic        par;
    logic [1:0]  stop;
    int unsigned gbit;
    logic [8:0]  exp_data;
    logic        exp_fe;
    logic        exp_pe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_word(input int unsigned d, input logic [8:0] data,
                             input logic f, input logic p);
    exp_t e;
    e.data = data;
    e.fe   = f;
    e.pe   = p;
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int unsigned d, input logic [8:0] data,
                           input logic f, input logic p);
    exp_t e;
    logic got;
    got = 1'b0;
    e   = '0;
    case (d)
      0:       if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
      1:       if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_word dut%0d: got data 0x%0h, expected no word", d, data);
    end else begin
      chk($sformatf("word_data dut%0d", d), 32'(data), 32'(e.data));
      chk($sformatf("word_frame_err dut%0d", d), 32'(f), 32'(e.fe));
      chk($sformatf("word_parity_err dut%0d", d), 32'(p), 32'(e.pe));
    end
  endtask

  // Scoreboard: every accepted word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld0 && rdy[0]) pop_check(0, {1'b0, d0}, fe0, pe0);
      if (vld1 && rdy[1]) pop_check(1, {1'b0, d1}, fe1, pe1);
      if (vld2 && rdy[2]) pop_check(2, {2'b0, d2}, fe2, pe2);
    end
  end

  // Drives one frame; gbit selects a bit cell that gets a 1-cycle inverted
  // pulse at its mid-point. The line is left at the last bit level.
  task automatic send(input int unsigned d, input logic [8:0] data, input logic par,
                      input logic [1:0] stop, input int unsigned gbit);
    logic [15:0] bits;
    int unsigned n, pos;
    n       = frame_bits(NDATA[d], NPAR[d], NSTOP[d]);
    bits    = '1;
    bits[0] = 1'b0;
    pos     = 1;
    for (int unsigned i = 0; i < NDATA[d]; i++) begin
      bits[pos] = data[i];
      pos++;
    end
    if (NPAR[d] != PARITY_NONE) begin
      bits[pos] = par;
      pos++;
    end
    for (int unsigned i = 0; i < NSTOP[d]; i++) begin
      bits[pos] = stop[i];
      pos++;
    end
    for (int unsigned b = 0; b < n; b++) begin
      for (int unsigned j = 0; j < CPB; j++) begin
        ser[d] = (b == gbit && j == HALF) ? ~bits[b] : bits[b];
        @(posedge clk);
        #2;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t vecs [12];
    int unsigned lat;
    logic        seen;

    vecs[0]  = '{0, 9'h03C, 1'b0, 2'b11, NONE, 9'h03C, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, NONE, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 3,    9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h000, 1'b0, 2'b11, 5,    9'h000, 1'b0, 1'b0};
    vecs[4]  = '{1, 9'h03C, 1'b1, 2'b11, NONE, 9'h03C, 1'b0, 1'b1};
    vecs[5]  = '{1, 9'h03C, 1'b0, 2'b11, NONE, 9'h03C, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h001, 1'b1, 2'b11, NONE, 9'h001, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h080, 1'b0, 2'b11, NONE, 9'h080, 1'b0, 1'b1};
    vecs[8]  = '{1, 9'h03C, 1'b0, 2'b10, NONE, 9'h03C, 1'b1, 1'b0};
    vecs[9]  = '{2, 9'h05D, 1'b0, 2'b11, NONE, 9'h05D, 1'b0, 1'b0};
    vecs[10] = '{2, 9'h02A, 1'b0, 2'b10, NONE, 9'h02A, 1'b1, 1'b0};
    vecs[11] = '{2, 9'h07F, 1'b0, 2'b01, NONE, 9'h07F, 1'b1, 1'b0};

    rst = 1'b1;
    ena = '1;
    ser = '1;
    rdy = '1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_flags", 32'({vld0, vld1, vld2, fe0, fe1, fe2, pe0, pe1, pe2,
                            ovr0, ovr1, ovr2, bsy0, bsy1, bsy2}), 32'(0));
    chk("reset_data", 32'({d0, d1, d2}), 32'(0));
    rst = 1'b0;
    tick(5);

    // Latency from driving the start bit: 2 sync cycles + completion + 1.
    expect_word(0, 9'h0A5, 1'b0, 1'b0);
    lat  = 0;
    seen = 1'b0;
    fork
      send(0, 9'h0A5, 1'b0, 2'b11, NONE);
      begin
        while (!seen && lat < 300) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (vld0) seen = 1'b1;
        end
      end
    join
    chk("latency_a5", lat, 2 + (frame_bits(8, 0, 1) - 1) * CPB + HALF + 2);
    ser[0] = 1'b1;
    tick(10);

    for (int unsigned i = 0; i < 12; i++) begin
      expect_word(vecs[i].dut, vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe);
      send(vecs[i].dut, vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].gbit);
      ser[vecs[i].dut] = 1'b1;
      tick(24);
    end

    // Frame error with the line held low: BREAK keeps busy until line high.
    expect_word(0, 9'h07F, 1'b1, 1'b0);
    send(0, 9'h07F, 1'b0, 2'b10, NONE);
    tick(40);
    chk("break_busy_low", 32'(bsy0), 32'(1));
    ser[0] = 1'b1;
    tick(1);
    chk("break_busy_rising", 32'(bsy0), 32'(1));
    tick(3);
    chk("break_exit", 32'(bsy0), 32'(0));
    expect_word(0, 9'h0C1, 1'b0, 1'b0);
    send(0, 9'h0C1, 1'b0, 2'b11, NONE);
    ser[0] = 1'b1;
    tick(24);

    // Start glitch: 5 cycles low, rejected at the start decision.
    ser[0] = 1'b0;
    tick(5);
    chk("glitch_busy", 32'(bsy0), 32'(1));
    ser[0] = 1'b1;
    tick(6);
    chk("glitch_decision_cycle", 32'(bsy0), 32'(1));
    tick(1);
    chk("glitch_idle", 32'(bsy0), 32'(0));
    tick(20);

    // Overrun: second word dropped while the first is held.
    rdy[0] = 1'b0;
    expect_word(0, 9'h0C1, 1'b0, 1'b0);
    send(0, 9'h0C1, 1'b0, 2'b11, NONE);
    ser[0] = 1'b1;
    tick(4);
    chk("ovr_first_valid", 32'({vld0, ovr0}), 32'(2'b10));
    send(0, 9'h099, 1'b0, 2'b11, NONE);
    ser[0] = 1'b1;
    tick(4);
    chk("ovr_set", 32'({vld0, ovr0}), 32'(2'b11));
    chk("ovr_data_kept", 32'(d0), 32'(8'hC1));
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    chk("ovr_cleared", 32'({vld0, ovr0}), 32'(0));
    rdy[0] = 1'b1;
    tick(10);

    // Reset mid-frame: nothing delivered, FSM idle.
    fork
      send(0, 9'h0FF, 1'b0, 2'b11, NONE);
      begin
        tick(50);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_midframe", 32'({bsy0, vld0}), 32'(0));
      end
    join
    ser[0] = 1'b1;
    tick(24);

    // 7N2 word, then ena dropped mid-way through a second word.
    expect_word(2, 9'h05D, 1'b0, 1'b0);
    send(2, 9'h05D, 1'b0, 2'b11, NONE);
    ser[2] = 1'b1;
    tick(24);
    fork
      send(2, 9'h033, 1'b0, 2'b11, NONE);
      begin
        tick(60);
        chk("ena_busy_before", 32'(bsy2), 32'(1));
        ena[2] = 1'b0;
        tick(1);
        chk("ena_busy_after", 32'(bsy2), 32'(0));
      end
    join
    ser[2] = 1'b1;
    tick(8);
    chk("ena_no_word", 32'(vld2), 32'(0));
    ena[2] = 1'b1;
    tick(24);

    chk("sb_drained", 32'(sb0.size() + sb1.size() + sb2.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
